// File: rtl/spi_tx_queue.sv
// spi_tx_queue: transmit byte FIFO feeding an SPI slave's data_in.
// Pops one byte per rising edge of the (asynchronous) slave busy line,
// drives intr while data is pending, keeps sticky overflow/underrun flags.
// Optional build macro SPI_TX_QUEUE_STATUS_EN: an empty-FIFO transfer sends
// a status byte {1, overflow, underrun, count} instead of FILL_BYTE.
module spi_tx_queue #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE = {DATA_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    spi_busy,
  output logic [DATA_WIDTH-1:0]   spi_data_in,
  output logic                    spi_data_in_valid,
  output logic                    intr,
  output logic                    overflow,
  output logic                    underrun,
  input  logic                    flags_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2:0]            busy_sync_q, busy_sync_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udr_q, udr_d;

  logic                  start_c;
  logic                  empty_c;
  logic                  pop_c;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] fill_c;

  // Status outputs decoded from the registered occupancy.
  assign count             = count_q;
  assign full              = (count_q == DEPTH_C);
  assign almost_full       = (count_q >= AFULL_C);
  assign intr              = (count_q != '0);
  assign spi_data_in       = data_q;
  assign spi_data_in_valid = valid_q;
  assign overflow          = ovf_q;
  assign underrun          = udr_q;

`ifdef SPI_TX_QUEUE_STATUS_EN
  logic [DATA_WIDTH-4:0] count_lo_c;
  assign count_lo_c = (DATA_WIDTH-3)'(count_q);
  assign fill_c     = {1'b1, ovf_q, udr_q, count_lo_c};
`else
  assign fill_c = FILL_BYTE;
`endif

  // Next-state logic: busy edge detect, push/pop, output load, sticky flags.
  always_comb begin
    busy_sync_d = {busy_sync_q[1:0], spi_busy};
    start_c     = (busy_sync_q[2:1] == 2'b01);
    empty_c     = (count_q == '0);
    pop_c       = start_c && !empty_c;
    push_c      = wr_en && (!full || pop_c);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = flags_clr ? 1'b0 : ovf_q;
    udr_d    = flags_clr ? 1'b0 : udr_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (start_c) begin
      valid_d = 1'b1;
      data_d  = pop_c ? mem_q[rd_ptr_q] : fill_c;
    end

    if (wr_en && full && !pop_c) ovf_d = 1'b1;
    if (start_c && empty_c)      udr_d = 1'b1;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_sync_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_sync_q <= busy_sync_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
    end
  end

  // Storage array; contents are don't-care until written, pointers gate reads.
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue (default build: FILL_BYTE on empty start).
module tb_spi_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, almost_full;
  logic [4:0] count;
  logic       spi_busy;
  logic [7:0] spi_data_in;
  logic       spi_data_in_valid;
  logic       intr, overflow, underrun;
  logic       flags_clr;

  int ncmp  = 0;
  int nfail = 0;
  logic [7:0] popped[$];

  spi_tx_queue dut (
    .clk               (clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .full              (full),
    .almost_full       (almost_full),
    .count             (count),
    .spi_busy          (spi_busy),
    .spi_data_in       (spi_data_in),
    .spi_data_in_valid (spi_data_in_valid),
    .intr              (intr),
    .overflow          (overflow),
    .underrun          (underrun),
    .flags_clr         (flags_clr)
  );

  always #5 clk = ~clk;

  // Record every byte strobed to the SPI slave.
  always @(negedge clk) begin
    if (spi_data_in_valid) popped.push_back(spi_data_in);
  end

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       busy;
    logic       clr;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] dat;
    logic       ov;
    logic       ur;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic wr, logic [7:0] wd, logic busy, logic clr,
                              logic [4:0] cnt, logic vld, logic [7:0] dat,
                              logic ov, logic ur);
    vec_t v;
    v.wr = wr; v.wd = wd; v.busy = busy; v.clr = clr;
    v.cnt = cnt; v.vld = vld; v.dat = dat; v.ov = ov; v.ur = ur;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic pulse_busy();
    spi_busy = 1'b1;
    repeat (3) step();
    spi_busy = 1'b0;
    repeat (3) step();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; spi_busy = 1'b0; flags_clr = 1'b0;

    // Cycle table: inputs applied before an edge, outputs checked after it.
    tbl[0]  = mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'h3C, 0, 0, 2, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 8'h00, 1, 0, 2, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 8'h00, 1, 0, 2, 0, 8'h00, 0, 0);
    tbl[4]  = mk(0, 8'h00, 1, 0, 1, 1, 8'hA5, 0, 0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0);
    tbl[9]  = mk(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0, 0);
    tbl[10] = mk(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0, 0);
    tbl[11] = mk(1, 8'h5A, 1, 0, 1, 1, 8'h3C, 0, 0);
    tbl[12] = mk(0, 8'h00, 0, 0, 1, 0, 8'h3C, 0, 0);
    tbl[13] = mk(0, 8'h00, 0, 0, 1, 0, 8'h3C, 0, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 1, 0, 8'h3C, 0, 0);
    tbl[15] = mk(0, 8'h00, 1, 0, 1, 0, 8'h3C, 0, 0);
    tbl[16] = mk(0, 8'h00, 1, 0, 1, 0, 8'h3C, 0, 0);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 1, 8'h5A, 0, 0);
    tbl[18] = mk(0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0);
    tbl[20] = mk(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 0);
    tbl[21] = mk(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 0);
    tbl[22] = mk(1, 8'h11, 1, 0, 1, 1, 8'hFF, 0, 1);
    tbl[23] = mk(0, 8'h00, 0, 1, 1, 0, 8'hFF, 0, 0);

    // Reset state.
    do_reset();
    check("rst_count", 32'(count), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_afull", 32'(almost_full), 32'h0);
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_data", 32'(spi_data_in), 32'h0);
    check("rst_valid", 32'(spi_data_in_valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_udr", 32'(underrun), 32'h0);

    // Table-driven cycle sequence.
    for (int i = 0; i < 24; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].wd;
      spi_busy = tbl[i].busy; flags_clr = tbl[i].clr;
      step();
      check($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("t%0d_intr", i), 32'(intr), 32'(tbl[i].cnt != 0));
      check($sformatf("t%0d_valid", i), 32'(spi_data_in_valid), 32'(tbl[i].vld));
      check($sformatf("t%0d_data", i), 32'(spi_data_in), 32'(tbl[i].dat));
      check($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ov));
      check($sformatf("t%0d_udr", i), 32'(underrun), 32'(tbl[i].ur));
    end
    wr_en = 1'b0; spi_busy = 1'b0; flags_clr = 1'b0;

    // Fill, almost_full threshold, overflow and clear.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 10) check("afull_at11", 32'(almost_full), 32'h0);
      if (i == 11) check("afull_at12", 32'(almost_full), 32'h1);
      if (i == 14) check("full_at15", 32'(full), 32'h0);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'h1);
    push(8'h77);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_count", 32'(count), 32'd16);
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);

    // Push coincident with pop while full: accepted, no overflow.
    spi_busy = 1'b1;
    repeat (2) step();
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_en = 1'b0;
    check("fullpp_count", 32'(count), 32'd16);
    check("fullpp_ovf", 32'(overflow), 32'h0);
    check("fullpp_valid", 32'(spi_data_in_valid), 32'h1);
    check("fullpp_data", 32'(spi_data_in), 32'h00);
    spi_busy = 1'b0;
    repeat (3) step();

    // Drain in order; the dropped 8'h77 must never appear.
    popped.delete();
    for (int i = 0; i < 16; i++) pulse_busy();
    check("drain_n", 32'(popped.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("drain_%0d", i), (i < popped.size()) ? 32'(popped[i]) : 32'hDEAD, 32'(i + 1));
    check("drain_count", 32'(count), 32'h0);
    check("drain_intr", 32'(intr), 32'h0);
    check("drain_udr", 32'(underrun), 32'h0);

    // Full pass across the pointer wrap.
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    popped.delete();
    for (int i = 0; i < 16; i++) pulse_busy();
    check("wrap_n", 32'(popped.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("wrap_%0d", i), (i < popped.size()) ? 32'(popped[i]) : 32'hDEAD, 32'h30 + 32'(i));

    // Busy held long gives exactly one pop.
    do_reset();
    push(8'hB1);
    push(8'hB2);
    popped.delete();
    spi_busy = 1'b1;
    repeat (100) step();
    check("long_n", 32'(popped.size()), 32'd1);
    check("long_data", (popped.size() > 0) ? 32'(popped[0]) : 32'hDEAD, 32'hB1);
    check("long_count", 32'(count), 32'd1);

    // Reset with busy high: queue flushed, one fill pulse after release.
    rst = 1'b1;
    repeat (2) step();
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_valid", 32'(spi_data_in_valid), 32'h0);
    popped.delete();
    rst = 1'b0;
    repeat (2) step();
    check("rel_novalid", 32'(spi_data_in_valid), 32'h0);
    step();
    check("rel_valid", 32'(spi_data_in_valid), 32'h1);
    repeat (10) step();
    check("rel_n", 32'(popped.size()), 32'd1);
    check("rel_data", (popped.size() > 0) ? 32'(popped[0]) : 32'hDEAD, 32'hFF);
    check("rel_udr", 32'(underrun), 32'h1);
    check("rel_count", 32'(count), 32'h0);
    spi_busy = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
